// File: rtl/trace_buffer.sv
// Retirement trace buffer: wrap, stop-when-full and trigger capture modes, oldest-first readout.
// Captures one retire per cycle with no backpressure; readout is a valid/ready stream that holds data until taken.
module trace_buffer #(
  parameter int DEPTH = 64,
  parameter int XLEN  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      retire_valid,
  input  logic [XLEN-1:0]           retire_pc,
  input  logic [XLEN-1:0]           retire_instr,
  input  logic                      arm,
  input  logic                      stop,
  input  logic [1:0]                mode,
  input  logic [XLEN-1:0]           trig_mask,
  input  logic [XLEN-1:0]           trig_value,
  input  logic [$clog2(DEPTH)-1:0]  post_count,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [XLEN-1:0]           rd_pc,
  output logic [XLEN-1:0]           rd_instr,
  output logic                      rd_last,
  output logic [1:0]                state_o,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic                      triggered
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_CNT  = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_REM  = AW'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    POST    = 2'd2,
    READOUT = 2'd3
  } state_t;

  state_t              state;
  logic [2*XLEN-1:0]   mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW:0]         rd_cnt;
  logic [AW-1:0]       remaining;
  logic [1:0]          mode_q;
  logic [XLEN-1:0]     mask_q;
  logic [XLEN-1:0]     value_q;
  logic [AW-1:0]       post_q;

  logic                capturing;
  logic                wr;
  logic                full;
  logic                hit;
  logic                go_ro;
  logic [AW:0]         cnt_nx;
  logic [AW-1:0]       wp_nx;
  logic                ovf_nx;

  always_comb begin
    capturing = (state == CAPTURE) || (state == POST);
    wr        = retire_valid && capturing;
    full      = (count == FULL_CNT);
    cnt_nx    = (wr && !full) ? count + 1'b1 : count;
    wp_nx     = wr ? wr_ptr + 1'b1 : wr_ptr;
    ovf_nx    = overflow || (wr && full);
    // Trigger is only armed in CAPTURE; matches during POST are ignored.
    hit       = wr && (state == CAPTURE) && (mode_q == 2'd2) &&
                (((retire_instr ^ value_q) & mask_q) == '0);
    go_ro     = stop ||
                (wr && (mode_q == 2'd1) && (cnt_nx == FULL_CNT)) ||
                (hit && (post_q == '0)) ||
                (wr && (state == POST) && (remaining == ONE_REM));
  end

  // Storage has no reset; rd_valid gates any stale content.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= {retire_pc, retire_instr};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rd_cnt    <= '0;
      count     <= '0;
      remaining <= '0;
      overflow  <= 1'b0;
      triggered <= 1'b0;
      mode_q    <= 2'd0;
      mask_q    <= '0;
      value_q   <= '0;
      post_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arm) begin
            state     <= CAPTURE;
            wr_ptr    <= '0;
            count     <= '0;
            remaining <= '0;
            overflow  <= 1'b0;
            triggered <= 1'b0;
            mode_q    <= (mode == 2'd3) ? 2'd0 : mode;
            mask_q    <= trig_mask;
            value_q   <= trig_value;
            post_q    <= post_count;
          end
        end
        CAPTURE, POST: begin
          wr_ptr   <= wp_nx;
          count    <= cnt_nx;
          overflow <= ovf_nx;
          if (hit) begin
            triggered <= 1'b1;
            remaining <= post_q;
          end else if (wr && (state == POST)) begin
            remaining <= remaining - 1'b1;
          end
          if (go_ro) begin
            state  <= READOUT;
            // After a wrap the slot about to be overwritten holds the oldest entry.
            rd_ptr <= ovf_nx ? wp_nx : '0;
            rd_cnt <= cnt_nx;
          end else if (hit) begin
            state <= POST;
          end
        end
        READOUT: begin
          if (rd_cnt == '0) begin
            state <= IDLE;
          end else if (rd_ready) begin
            rd_ptr <= rd_ptr + 1'b1;
            rd_cnt <= rd_cnt - 1'b1;
            if (rd_cnt == ONE_CNT) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign state_o           = state;
  assign rd_valid          = (state == READOUT) && (rd_cnt != '0);
  assign rd_last           = rd_valid && (rd_cnt == ONE_CNT);
  assign {rd_pc, rd_instr} = mem[rd_ptr];

endmodule

// File: tb/tb_trace_buffer.sv
// Bench for trace_buffer (DEPTH=8): directed scenarios plus randomized sessions against a queue-based model.
module tb_trace_buffer;

  localparam int DEPTH = 8;
  localparam int XLEN  = 32;
  localparam int AW    = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            retire_valid = 1'b0;
  logic [XLEN-1:0] retire_pc = '0;
  logic [XLEN-1:0] retire_instr = '0;
  logic            arm = 1'b0;
  logic            stop = 1'b0;
  logic [1:0]      mode = 2'd0;
  logic [XLEN-1:0] trig_mask = '0;
  logic [XLEN-1:0] trig_value = '0;
  logic [AW-1:0]   post_count = '0;
  logic            rd_valid;
  logic            rd_ready = 1'b0;
  logic [XLEN-1:0] rd_pc;
  logic [XLEN-1:0] rd_instr;
  logic            rd_last;
  logic [1:0]      state_o;
  logic [AW:0]     count;
  logic            overflow;
  logic            triggered;

  trace_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_instr(retire_instr),
    .arm(arm), .stop(stop), .mode(mode),
    .trig_mask(trig_mask), .trig_value(trig_value), .post_count(post_count),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc), .rd_instr(rd_instr),
    .rd_last(rd_last), .state_o(state_o), .count(count),
    .overflow(overflow), .triggered(triggered)
  );

  initial forever #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: the buffer is a queue of at most DEPTH {pc,instr} entries.
  int          m_st = 0;
  logic [63:0] q[$];
  logic [63:0] rdq[$];
  int          m_count = 0;
  bit          m_ovf = 0;
  bit          m_trig = 0;
  int          m_rem = 0;
  int          m_mode = 0;
  logic [31:0] m_mask = '0;
  logic [31:0] m_val = '0;
  int          m_post = 0;

  task automatic model_step();
    bit go;
    bit to_post;
    if (!rst_n) begin
      m_st = 0; q.delete(); rdq.delete();
      m_count = 0; m_ovf = 0; m_trig = 0; m_rem = 0;
    end else begin
      case (m_st)
        0: if (arm) begin
          m_st = 1; q.delete(); m_count = 0; m_ovf = 0; m_trig = 0; m_rem = 0;
          m_mode = (mode == 2'd3) ? 0 : int'(mode);
          m_mask = trig_mask; m_val = trig_value; m_post = int'(post_count);
        end
        1, 2: begin
          go = 0; to_post = 0;
          if (retire_valid) begin
            q.push_back({retire_pc, retire_instr});
            if (q.size() > DEPTH) begin q.delete(0); m_ovf = 1; end
            m_count = q.size();
            if (m_mode == 1 && q.size() == DEPTH) go = 1;
            if (m_st == 1 && m_mode == 2 && ((retire_instr & m_mask) == (m_val & m_mask))) begin
              m_trig = 1; m_rem = m_post;
              if (m_post == 0) go = 1; else to_post = 1;
            end else if (m_st == 2) begin
              m_rem = m_rem - 1;
              if (m_rem == 0) go = 1;
            end
          end
          if (stop) go = 1;
          if (go) begin m_st = 3; rdq = q; end
          else if (to_post) m_st = 2;
        end
        default: begin
          if (rdq.size() == 0) m_st = 0;
          else if (rd_ready) begin
            rdq.delete(0);
            if (rdq.size() == 0) m_st = 0;
          end
        end
      endcase
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  // Every cycle, all outputs are compared against the model.
  initial forever begin
    @(negedge clk);
    check_eq("state", 64'(state_o), 64'(m_st));
    check_eq("count", 64'(count), 64'(m_count));
    check_eq("overflow", 64'(overflow), 64'(m_ovf));
    check_eq("triggered", 64'(triggered), 64'(m_trig));
    check_eq("rd_valid", 64'(rd_valid), 64'(m_st == 3 && rdq.size() > 0));
    check_eq("rd_last", 64'(rd_last), 64'(m_st == 3 && rdq.size() == 1));
    if (m_st == 3 && rdq.size() > 0) check_eq("rd_data", {rd_pc, rd_instr}, rdq[0]);
  end

  logic [31:0] got_pc[$];
  bit          got_last[$];
  bit          stall_pend = 0;
  logic [31:0] stall_pc = '0;

  task automatic cyc(input bit rv, input logic [31:0] pc, input logic [31:0] ins,
                     input bit a, input bit s, input bit rr);
    retire_valid = rv; retire_pc = pc; retire_instr = ins;
    arm = a; stop = s; rd_ready = rr;
    #1;
    if (stall_pend) begin
      check_eq("stall_valid", 64'(rd_valid), 64'(1));
      check_eq("stall_pc", 64'(rd_pc), 64'(stall_pc));
    end
    stall_pend = rd_valid && !rd_ready;
    stall_pc = rd_pc;
    if (rd_valid && rd_ready) begin
      got_pc.push_back(rd_pc);
      got_last.push_back(rd_last);
    end
    @(negedge clk);
  endtask

  // pat 0: always ready, 1: ready 1-0-0-1 repeating, 2: random
  task automatic drain(input int pat);
    int k;
    bit rr;
    k = 0;
    while (state_o == 2'd3 && k < 200) begin
      case (pat)
        0: rr = 1;
        1: rr = (k % 4 == 0) || (k % 4 == 3);
        default: rr = $urandom_range(0, 1) == 1;
      endcase
      cyc(0, '0, '0, 0, 0, rr);
      k++;
    end
    check_eq("drain_done", 64'(state_o), 64'(0));
  endtask

  task automatic check_list(input string tag, input logic [31:0] base, input int n);
    check_eq({tag, "_len"}, 64'(got_pc.size()), 64'(n));
    for (int i = 0; i < n && i < got_pc.size(); i++) begin
      check_eq({tag, "_pc"}, 64'(got_pc[i]), 64'(base + 32'(4 * i)));
      check_eq({tag, "_last"}, 64'(got_last[i]), 64'(i == n - 1));
    end
  endtask

  function automatic logic [31:0] plain_instr();
    logic [31:0] r;
    r = $urandom();
    return {r[31:7], 7'h13};
  endfunction

  initial begin
    logic [31:0] ins;
    repeat (3) @(negedge clk);
    check_eq("rst_state", 64'(state_o), 64'(0));
    check_eq("rst_count", 64'(count), 64'(0));
    check_eq("rst_rd_valid", 64'(rd_valid), 64'(0));
    check_eq("rst_overflow", 64'(overflow), 64'(0));
    rst_n = 1'b1;
    cyc(1, 32'h40, plain_instr(), 0, 1, 1);

    // Stop-when-full: READOUT after the 8th retire, later retires ignored.
    mode = 2'd1;
    cyc(0, '0, '0, 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 32'h100 + 32'(4 * i), plain_instr(), 0, 0, 0);
      if (i == 7) check_eq("m1_state_after8", 64'(state_o), 64'(3));
    end
    got_pc.delete(); got_last.delete();
    drain(0);
    check_list("m1_read", 32'h100, 8);
    check_eq("m1_overflow", 64'(overflow), 64'(0));

    // Wrap: 11 retires then stop, oldest-first from the 4th entry.
    mode = 2'd0;
    cyc(0, '0, '0, 1, 0, 0);
    for (int i = 0; i < 11; i++) cyc(1, 32'(4 * i), plain_instr(), 0, 0, 0);
    cyc(0, '0, '0, 0, 1, 0);
    check_eq("m0_overflow", 64'(overflow), 64'(1));
    check_eq("m0_count", 64'(count), 64'(8));
    got_pc.delete(); got_last.delete();
    drain(0);
    check_list("m0_read", 32'h0C, 8);

    // Trigger on ecall at the 5th retire, two post entries, stalled readout.
    mode = 2'd2; trig_mask = 32'h7F; trig_value = 32'h73; post_count = 3'd2;
    cyc(0, '0, '0, 1, 0, 0);
    for (int i = 0; i < 7; i++) begin
      ins = (i == 4) ? 32'h0000_0073 : plain_instr();
      cyc(1, 32'h200 + 32'(4 * i), ins, 0, 0, 0);
      if (i == 4) check_eq("m2_triggered", 64'(triggered), 64'(1));
      if (i == 5) check_eq("m2_post", 64'(state_o), 64'(2));
      if (i == 6) check_eq("m2_readout", 64'(state_o), 64'(3));
    end
    got_pc.delete(); got_last.delete();
    drain(1);
    check_list("m2_read", 32'h200, 7);

    // Asynchronous reset in POST, then a clean capture.
    post_count = 3'd5;
    cyc(0, '0, '0, 1, 0, 0);
    for (int i = 0; i < 3; i++)
      cyc(1, 32'h280 + 32'(4 * i), (i == 2) ? 32'h0000_0073 : plain_instr(), 0, 0, 0);
    check_eq("pre_rst_state", 64'(state_o), 64'(2));
    check_eq("pre_rst_count", 64'(count), 64'(3));
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_state", 64'(state_o), 64'(0));
    check_eq("arst_count", 64'(count), 64'(0));
    check_eq("arst_rd_valid", 64'(rd_valid), 64'(0));
    check_eq("arst_triggered", 64'(triggered), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    stall_pend = 0;
    mode = 2'd1;
    cyc(0, '0, '0, 1, 0, 0);
    check_eq("rearm_state", 64'(state_o), 64'(1));
    cyc(1, 32'h300, plain_instr(), 0, 0, 0);
    cyc(1, 32'h304, plain_instr(), 0, 0, 0);
    cyc(0, '0, '0, 0, 1, 0);
    got_pc.delete(); got_last.delete();
    drain(0);
    check_list("rearm_read", 32'h300, 2);

    // Arm then stop with nothing captured.
    mode = 2'd0;
    cyc(0, '0, '0, 1, 0, 0);
    cyc(0, '0, '0, 0, 1, 1);
    check_eq("empty_state", 64'(state_o), 64'(3));
    check_eq("empty_rd_valid", 64'(rd_valid), 64'(0));
    cyc(0, '0, '0, 0, 0, 1);
    check_eq("empty_idle", 64'(state_o), 64'(0));

    // Randomized sessions; the per-cycle model comparison does the checking.
    for (int s = 0; s < 12; s++) begin
      mode = 2'($urandom_range(0, 3));
      trig_mask = 32'h7F; trig_value = 32'h73;
      post_count = 3'($urandom_range(0, 7));
      for (int k = 0; k < 3; k++)
        cyc($urandom_range(0, 1) == 1, $urandom(), plain_instr(), 0,
            $urandom_range(0, 1) == 1, 1);
      cyc(0, '0, '0, 1, 0, 1);
      for (int k = 0; k < 60 && (m_st == 1 || m_st == 2); k++) begin
        ins = plain_instr();
        if ($urandom_range(0, 9) == 0) ins[6:0] = 7'h73;
        cyc($urandom_range(0, 3) != 0, $urandom(), ins,
            $urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 1) == 1);
      end
      if (m_st == 1 || m_st == 2) cyc(0, '0, '0, 0, 1, 0);
      drain(2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
